fwd_hazard_ctrl: RTL and testbench

Forwarding and hazard controller for the 5-stage RISC-V pipeline. Keeps a shadow copy of the destination register and write/load flags for the EX, MEM and WB stages. From these it drives the registered `ForwardASel`/`ForwardBSel` selects consumed by the execute stage's forwarding muxes, together with load-use stall and branch flush controls. Sits beside the ID/EX pipeline register and is clocked with it.

---
 rtl/pipe_pkg.sv | 18 +
 rtl/fwd_sel_calc.sv | 26 ++
 rtl/fwd_hazard_ctrl.sv | 106 ++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: forwarding-select encoding, shadow-stage record
// and the hard-wired zero register index.
package pipe_pkg;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_WB  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;

  localparam logic [4:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       RegWEn;
    logic       MemRead;
  } stage_t;

endpackage

// File: rtl/fwd_sel_calc.sv
// Per-operand forwarding priority compare: the producer now in EX (will be in
// MEM) outranks the one now in MEM (will be in WB).
module fwd_sel_calc
  import pipe_pkg::*;
(
  input  logic [4:0] rs_i,
  input  logic       use_i,
  input  logic       ex_wr_i,
  input  logic [4:0] ex_rd_i,
  input  logic       mem_wr_i,
  input  logic [4:0] mem_rd_i,
  output logic [1:0] sel_o
);

  always_comb begin
    sel_o = FWD_RF;
    if (use_i && (rs_i != REG_X0)) begin
      if (ex_wr_i && (ex_rd_i == rs_i)) begin
        sel_o = FWD_MEM;
      end else if (mem_wr_i && (mem_rd_i == rs_i)) begin
        sel_o = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard controller: shadows rd/write/load info for EX, MEM, WB
// and produces registered forward selects plus load-use stall and flush controls.
module fwd_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned XLEN_CNT = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4:0]          id_rs1,
  input  logic [4:0]          id_rs2,
  input  logic                id_use_rs1,
  input  logic                id_use_rs2,
  input  logic [4:0]          id_rd,
  input  logic                id_RegWEn,
  input  logic                id_MemRead,
  input  logic                id_valid,
  input  logic                ex_flush,
  output logic [1:0]          ForwardASel,
  output logic [1:0]          ForwardBSel,
  output logic                stall,
  output logic                bubble_ex,
  output logic                flush_id,
  output logic [XLEN_CNT-1:0] stall_cnt,
  output logic [XLEN_CNT-1:0] flush_cnt,
  output stage_t [2:0]        shadow_dbg
);

  stage_t ex_q, mem_q, wb_q, ex_d;
  logic [1:0] fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d, sel_a, sel_b;
  logic [XLEN_CNT-1:0] stall_cnt_q, flush_cnt_q;
  logic load_use, ex_wr, mem_wr;

  assign ex_wr  = ex_q.valid  && ex_q.RegWEn  && (ex_q.rd  != REG_X0);
  assign mem_wr = mem_q.valid && mem_q.RegWEn && (mem_q.rd != REG_X0);

  assign load_use = ex_q.valid && ex_q.MemRead && (ex_q.rd != REG_X0) && id_valid &&
                    ((id_use_rs1 && (id_rs1 == ex_q.rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_q.rd)));

  // A flush kills the stalled consumer anyway, so it suppresses the stall.
  assign flush_id  = ex_flush;
  assign stall     = load_use && !ex_flush;
  assign bubble_ex = load_use || ex_flush;

  fwd_sel_calc u_sel_a (
    .rs_i     (id_rs1),
    .use_i    (id_use_rs1),
    .ex_wr_i  (ex_wr),
    .ex_rd_i  (ex_q.rd),
    .mem_wr_i (mem_wr),
    .mem_rd_i (mem_q.rd),
    .sel_o    (sel_a)
  );

  fwd_sel_calc u_sel_b (
    .rs_i     (id_rs2),
    .use_i    (id_use_rs2),
    .ex_wr_i  (ex_wr),
    .ex_rd_i  (ex_q.rd),
    .mem_wr_i (mem_wr),
    .mem_rd_i (mem_q.rd),
    .sel_o    (sel_b)
  );

  always_comb begin
    ex_d    = '0;
    fwd_a_d = FWD_RF;
    fwd_b_d = FWD_RF;
    if (!bubble_ex && id_valid) begin
      ex_d.valid   = 1'b1;
      ex_d.rd      = id_rd;
      ex_d.RegWEn  = id_RegWEn;
      ex_d.MemRead = id_MemRead;
      fwd_a_d      = sel_a;
      fwd_b_d      = sel_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      fwd_a_q     <= FWD_RF;
      fwd_b_q     <= FWD_RF;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= ex_q;
      wb_q    <= mem_q;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
      if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (ex_flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign ForwardASel = fwd_a_q;
  assign ForwardBSel = fwd_b_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;
  assign shadow_dbg  = {wb_q, mem_q, ex_q};

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: directed pipeline scenarios plus random traffic
// checked against an in-flight instruction history model.
module tb_fwd_hazard_ctrl;
  import pipe_pkg::*;

  localparam int CW = 4;
  localparam logic [CW-1:0] CMAX = '1;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic id_use_rs1, id_use_rs2, id_RegWEn, id_MemRead, id_valid, ex_flush;
  logic [1:0] ForwardASel, ForwardBSel;
  logic stall, bubble_ex, flush_id;
  logic [CW-1:0] stall_cnt, flush_cnt;
  stage_t [2:0] shadow_dbg;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(.XLEN_CNT(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_RegWEn(id_RegWEn), .id_MemRead(id_MemRead), .id_valid(id_valid),
    .ex_flush(ex_flush),
    .ForwardASel(ForwardASel), .ForwardBSel(ForwardBSel),
    .stall(stall), .bubble_ex(bubble_ex), .flush_id(flush_id),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .shadow_dbg(shadow_dbg)
  );

  // Model: instructions that entered EX, newest first ([0] in EX, [1] in MEM, [2] in WB).
  typedef struct {
    logic       v;
    logic [4:0] rd;
    logic       we;
    logic       ld;
  } ins_t;

  ins_t hist[$];
  logic [1:0] exp_a, exp_b;
  logic [CW-1:0] exp_scnt, exp_fcnt;

  function automatic logic m_load_use();
    ins_t p;
    p = hist[0];
    return p.v && p.ld && (p.rd != 5'd0) && id_valid &&
           ((id_use_rs1 && id_rs1 == p.rd) || (id_use_rs2 && id_rs2 == p.rd));
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] rs, input logic u);
    if (!u || rs == 5'd0) return 2'd0;
    for (int k = 0; k < 2; k++) begin
      if (hist[k].v && hist[k].we && hist[k].rd != 5'd0 && hist[k].rd == rs)
        return (k == 0) ? 2'd2 : 2'd1;
    end
    return 2'd0;
  endfunction

  task automatic model_reset();
    ins_t inv;
    inv = '{v: 1'b0, rd: 5'd0, we: 1'b0, ld: 1'b0};
    hist = {inv, inv, inv};
    exp_a = 2'd0;
    exp_b = 2'd0;
    exp_scnt = '0;
    exp_fcnt = '0;
  endtask

  // Advance one clock, updating the model from the inputs present before the edge.
  task automatic tick();
    ins_t e;
    logic lu, bub;
    logic [1:0] na, nb;
    lu  = m_load_use();
    bub = ex_flush || lu;
    na  = (bub || !id_valid) ? 2'd0 : m_fwd(id_rs1, id_use_rs1);
    nb  = (bub || !id_valid) ? 2'd0 : m_fwd(id_rs2, id_use_rs2);
    e   = '{v: !bub && id_valid, rd: id_rd, we: id_RegWEn, ld: id_MemRead};
    if (rst) begin
      model_reset();
    end else begin
      hist.push_front(e);
      void'(hist.pop_back());
      exp_a = na;
      exp_b = nb;
      if (lu && !ex_flush && exp_scnt != CMAX) exp_scnt = exp_scnt + 1'b1;
      if (ex_flush && exp_fcnt != CMAX) exp_fcnt = exp_fcnt + 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                       input logic u2, input logic [4:0] rd, input logic we,
                       input logic ld, input logic v, input logic fl);
    id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    id_rd = rd; id_RegWEn = we; id_MemRead = ld; id_valid = v; ex_flush = fl;
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) begin
      issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    total++; if (ForwardASel !== 2'd0) begin bad++; $display("FAIL reset_fwd_a: got %0d want 0", ForwardASel); end
    total++; if (ForwardBSel !== 2'd0) begin bad++; $display("FAIL reset_fwd_b: got %0d want 0", ForwardBSel); end
    total++; if (stall_cnt !== '0 || flush_cnt !== '0) begin bad++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
    total++; if ({stall, bubble_ex, flush_id} !== 3'b000) begin bad++; $display("FAIL reset_ctrl: got %b want 000", {stall, bubble_ex, flush_id}); end
    total++; if ({shadow_dbg[2].valid, shadow_dbg[1].valid, shadow_dbg[0].valid} !== 3'b000) begin
      bad++; $display("FAIL reset_shadow_valid: got %b want 000", {shadow_dbg[2].valid, shadow_dbg[1].valid, shadow_dbg[0].valid}); end
  endtask

  task automatic test_alu_chain();
    drain();
    issue(5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);  // add x5,x1,x2
    tick();
    issue(5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0);  // sub x6,x5,x1
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL chain_stall: got %b want 0", stall); end
    tick();
    total++; if (ForwardASel !== 2'd2) begin bad++; $display("FAIL chain_fwd_a: got %0d want 2", ForwardASel); end
    total++; if (ForwardBSel !== 2'd0) begin bad++; $display("FAIL chain_fwd_b: got %0d want 0", ForwardBSel); end
  endtask

  task automatic test_dist_two();
    drain();
    issue(5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);    // add x5
    tick();
    issue(5'd11, 1'b1, 5'd12, 1'b1, 5'd10, 1'b1, 1'b0, 1'b1, 1'b0); // unrelated
    tick();
    issue(5'd2, 1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0);    // or x7,x2,x5
    tick();
    total++; if (ForwardBSel !== 2'd1) begin bad++; $display("FAIL dist2_fwd_b: got %0d want 1", ForwardBSel); end
    total++; if (ForwardASel !== 2'd0) begin bad++; $display("FAIL dist2_fwd_a: got %0d want 0", ForwardASel); end
  endtask

  task automatic test_load_use();
    drain();
    issue(5'd2, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0);   // lw x8
    tick();
    issue(5'd8, 1'b1, 5'd8, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0);   // add x9,x8,x8
    total++; if ({stall, bubble_ex, flush_id} !== 3'b110) begin bad++; $display("FAIL lu_ctrl: got %b want 110", {stall, bubble_ex, flush_id}); end
    tick();
    total++; if ({stall, bubble_ex} !== 2'b00) begin bad++; $display("FAIL lu_release: got %b want 00", {stall, bubble_ex}); end
    tick();
    total++; if (ForwardASel !== 2'd1 || ForwardBSel !== 2'd1) begin bad++; $display("FAIL lu_fwd: got %0d/%0d want 1/1", ForwardASel, ForwardBSel); end
    total++; if (stall_cnt !== 4'd1) begin bad++; $display("FAIL lu_stall_cnt: got %0d want 1", stall_cnt); end
  endtask

  task automatic test_x0();
    drain();
    issue(5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);   // add x0
    tick();
    issue(5'd0, 1'b1, 5'd0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0);   // add x3,x0,x0
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL x0_stall: got %b want 0", stall); end
    tick();
    total++; if (ForwardASel !== 2'd0 || ForwardBSel !== 2'd0) begin bad++; $display("FAIL x0_fwd: got %0d/%0d want 0/0", ForwardASel, ForwardBSel); end
  endtask

  task automatic test_double_producer();
    drain();
    issue(5'd1, 1'b1, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    issue(5'd1, 1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    issue(5'd4, 1'b1, 5'd4, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    total++; if (ForwardASel !== 2'd2 || ForwardBSel !== 2'd2) begin bad++; $display("FAIL double_fwd: got %0d/%0d want 2/2", ForwardASel, ForwardBSel); end
  endtask

  task automatic test_flush_stall();
    drain();
    issue(5'd2, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0);   // lw x8
    tick();
    issue(5'd8, 1'b1, 5'd8, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1);   // dependent + flush
    total++; if ({stall, bubble_ex, flush_id} !== 3'b011) begin bad++; $display("FAIL fs_ctrl: got %b want 011", {stall, bubble_ex, flush_id}); end
    tick();
    total++; if (flush_cnt !== 4'd1) begin bad++; $display("FAIL fs_flush_cnt: got %0d want 1", flush_cnt); end
    total++; if (stall_cnt !== 4'd1) begin bad++; $display("FAIL fs_stall_cnt: got %0d want 1", stall_cnt); end
    rst = 1'b1;
    issue(5'd8, 1'b1, 5'd8, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    rst = 1'b0;
    total++; if (stall_cnt !== '0 || flush_cnt !== '0) begin bad++; $display("FAIL fs_rst_cnt: got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
    total++; if (ForwardASel !== 2'd0 || ForwardBSel !== 2'd0) begin bad++; $display("FAIL fs_rst_fwd: got %0d/%0d want 0/0", ForwardASel, ForwardBSel); end
  endtask

  task automatic test_random();
    logic e_stall, e_bub;
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 99) < 2);
      issue(5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 5) != 0),
            ($urandom_range(0, 9) == 0));
      e_stall = m_load_use() && !ex_flush;
      e_bub   = m_load_use() || ex_flush;
      total++; if ({stall, bubble_ex, flush_id} !== {e_stall, e_bub, ex_flush}) begin
        bad++; $display("FAIL rnd_ctrl[%0d]: got %b want %b", i, {stall, bubble_ex, flush_id}, {e_stall, e_bub, ex_flush}); end
      tick();
      rst = 1'b0;
      total++; if (ForwardASel !== exp_a || ForwardBSel !== exp_b) begin
        bad++; $display("FAIL rnd_fwd[%0d]: got %0d/%0d want %0d/%0d", i, ForwardASel, ForwardBSel, exp_a, exp_b); end
      total++; if (stall_cnt !== exp_scnt || flush_cnt !== exp_fcnt) begin
        bad++; $display("FAIL rnd_cnt[%0d]: got %0d/%0d want %0d/%0d", i, stall_cnt, flush_cnt, exp_scnt, exp_fcnt); end
    end
  endtask

  task automatic test_back_to_back();
    // Long run without reset drives both counters into saturation.
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      issue(5'd2, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0);
      tick();
      issue(5'd8, 1'b1, 5'd3, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1, (i % 2) == 0);
      tick();
    end
    total++; if (stall_cnt !== exp_scnt || flush_cnt !== exp_fcnt) begin
      bad++; $display("FAIL b2b_sat_cnt: got %0d/%0d want %0d/%0d", stall_cnt, flush_cnt, exp_scnt, exp_fcnt); end
    total++; if (flush_cnt !== CMAX) begin bad++; $display("FAIL b2b_flush_sat: got %0d want %0d", flush_cnt, CMAX); end
  endtask

  initial begin
    rst = 1'b1;
    model_reset();
    test_reset();
    test_alu_chain();
    test_dist_two();
    test_load_use();
    test_x0();
    test_double_producer();
    test_flush_stall();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
